seq_restoring_divider: RTL

SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

---
 rtl/seq_restoring_divider.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, three-state FSM.
// Optional divide-by-zero shortcut and dz flag enabled by defining DIV_BYZERO_EN.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef DIV_BYZERO_EN
  ,output logic         dz
`endif
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef DIV_BYZERO_EN
  logic          dz_q, dz_d;
`endif

  logic [VW:0]   trial_s;
  logic          ge_s;
  logic [VW-1:0] diff_s;
  logic [VW-1:0] step_rem_s;

  // One restoring step: trial is the VW+1-bit partial remainder after shifting in the next bit.
  // A held remainder is always below the divisor, so only its low VW bits are kept.
  always_comb begin
    trial_s    = {prem_q, dvd_q[DW-1]};
    ge_s       = (trial_s >= {1'b0, dvs_q});
    diff_s     = trial_s[VW-1:0] - dvs_q;
    if (ge_s) begin
      step_rem_s = diff_s;
    end else begin
      step_rem_s = trial_s[VW-1:0];
    end
  end

  // Next-state and datapath update; dvd_q shifts out dividend bits while quotient bits fill in.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_BYZERO_EN
    dz_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = {VW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
`ifdef DIV_BYZERO_EN
          if (divisor == {VW{1'b0}}) begin
            state_d     = S_DONE;
            quotient_d  = {DW{1'b1}};
            remainder_d = {VW{1'b1}};
            dz_d        = 1'b1;
          end else begin
            state_d = S_RUN;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        dvd_d  = {dvd_q[DW-2:0], ge_s};
        prem_d = step_rem_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(DW - 1)) begin
          state_d     = S_DONE;
          quotient_d  = {dvd_q[DW-2:0], ge_s};
          remainder_d = step_rem_s;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= {DW{1'b0}};
      dvs_q       <= {VW{1'b0}};
      prem_q      <= {VW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {DW{1'b0}};
      remainder_q <= {VW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_BYZERO_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_BYZERO_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_BYZERO_EN
  assign dz        = dz_q;
`endif

endmodule
